// File: rtl/tlc_multi_if.sv
// Register write port between the intersection host and tlc_multi.
// The host drives addr/data/valid; the controller answers with ready/err one cycle later.
interface tlc_multi_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  err;

    modport master (output addr, output data, output valid, input ready, input err);
    modport slave  (input addr, input data, input valid, output ready, output err);
endinterface

// File: rtl/tlc_multi.sv
// Multi-approach traffic light controller: round-robin green -> yellow -> all-red,
// with per-approach green times and shared yellow/all-red times in seconds.
module tlc_multi #(
    parameter int NUM_DIR    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TICK_DIV   = 1000,
    parameter int DIR_W      = $clog2(NUM_DIR)
) (
    input  logic                 clk,
    input  logic                 rst,
    tlc_multi_if.slave           bus,
    input  logic                 hold,
    output logic [1:0]           phase,
    output logic [DIR_W-1:0]     cur_dir,
    output logic [2*NUM_DIR-1:0] lights,
    output logic                 phase_start
);
    localparam logic [1:0] PH_RESET  = 2'b00;
    localparam logic [1:0] PH_ALLRED = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;
    localparam logic [1:0] PH_GREEN  = 2'b11;

    localparam logic [1:0] LAMP_OFF    = 2'b00;
    localparam logic [1:0] LAMP_RED    = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_GREEN  = 2'b11;

    localparam int             TCW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

    logic [DATA_WIDTH-1:0] tgreen_reg [NUM_DIR];
    logic [DATA_WIDTH-1:0] tyellow_reg;
    logic [DATA_WIDTH-1:0] tallred_reg;
    logic                  ready_reg;
    logic                  err_reg;

    logic [1:0]            phase_reg;
    logic [1:0]            phase_next;
    logic [DIR_W-1:0]      cur_dir_reg;
    logic [DIR_W-1:0]      cur_dir_next;
    logic [2*NUM_DIR-1:0]  lights_reg;
    logic [2*NUM_DIR-1:0]  lights_next;
    logic                  phase_start_reg;
    logic                  enter_next;
    logic [TCW-1:0]        tick_cnt_reg;
    logic [DATA_WIDTH-1:0] sec_cnt_reg;
    logic [DATA_WIDTH-1:0] sec_load_next;

    logic                  addr_ok;
    logic                  tick;
    logic                  exit_now;
    logic [DATA_WIDTH-1:0] yellow_load;

    logic [DIR_W-1:0]      cand     [NUM_DIR];
    logic [NUM_DIR-1:0]    cand_nz;
    logic                  found;
    logic [DIR_W-1:0]      found_idx;

    // ---------------- register file ----------------
    assign addr_ok = ({{(32-ADDR_WIDTH){1'b0}}, bus.addr} < 32'(NUM_DIR + 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIR; i++) begin
                tgreen_reg[i] <= '0;
            end
            tyellow_reg <= '0;
            tallred_reg <= '0;
            ready_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (bus.valid) begin
                for (int i = 0; i < NUM_DIR; i++) begin
                    if (bus.addr == ADDR_WIDTH'(i)) begin
                        tgreen_reg[i] <= bus.data;
                    end
                end
                if (bus.addr == ADDR_WIDTH'(NUM_DIR)) begin
                    tyellow_reg <= bus.data;
                end
                if (bus.addr == ADDR_WIDTH'(NUM_DIR + 1)) begin
                    tallred_reg <= bus.data;
                end
            end
            ready_reg <= bus.valid && addr_ok;
            err_reg   <= bus.valid && !addr_ok;
        end
    end

    assign bus.ready = ready_reg;
    assign bus.err   = err_reg;

    // ---------------- next-green search ----------------
    // cand[k] is the approach k+1 steps after cur_dir, so cand[NUM_DIR-1] is cur_dir itself.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIR; gi++) begin : g_cand
            logic [DIR_W:0] sum;
            assign sum         = {1'b0, cur_dir_reg} + (DIR_W+1)'(gi + 1);
            assign cand[gi]    = (sum >= (DIR_W+1)'(NUM_DIR)) ? DIR_W'(sum - (DIR_W+1)'(NUM_DIR))
                                                              : DIR_W'(sum);
            assign cand_nz[gi] = (tgreen_reg[cand[gi]] != '0);
        end
    endgenerate

    always_comb begin
        found     = 1'b0;
        found_idx = cur_dir_reg;
        for (int k = 0; k < NUM_DIR; k++) begin
            if (!found && cand_nz[k]) begin
                found     = 1'b1;
                found_idx = cand[k];
            end
        end
    end

    // ---------------- timing ----------------
    assign tick        = !hold && (tick_cnt_reg == TICK_LAST);
    // A zero-length all-red still has to occupy one clock, hence the sec_cnt==0 exit.
    assign exit_now    = !hold && ((sec_cnt_reg == '0) || (tick && sec_cnt_reg == DATA_WIDTH'(1)));
    assign yellow_load = (tyellow_reg == '0) ? DATA_WIDTH'(1) : tyellow_reg;

    always_comb begin
        phase_next    = phase_reg;
        cur_dir_next  = cur_dir_reg;
        sec_load_next = sec_cnt_reg;
        enter_next    = 1'b0;
        case (phase_reg)
            PH_RESET: begin
                enter_next    = 1'b1;
                phase_next    = PH_ALLRED;
                sec_load_next = tallred_reg;
            end
            PH_ALLRED: begin
                if (exit_now) begin
                    enter_next = 1'b1;
                    if (found) begin
                        phase_next    = PH_GREEN;
                        cur_dir_next  = found_idx;
                        sec_load_next = tgreen_reg[found_idx];
                    end else begin
                        phase_next    = PH_ALLRED;
                        sec_load_next = tallred_reg;
                    end
                end
            end
            PH_GREEN: begin
                if (exit_now) begin
                    enter_next    = 1'b1;
                    phase_next    = PH_YELLOW;
                    sec_load_next = yellow_load;
                end
            end
            PH_YELLOW: begin
                if (exit_now) begin
                    enter_next    = 1'b1;
                    phase_next    = PH_ALLRED;
                    sec_load_next = tallred_reg;
                end
            end
            default: begin
                phase_next = PH_RESET;
            end
        endcase
    end

    // Lamp codes are derived from the upcoming state so they switch together with phase.
    generate
        for (gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
            always_comb begin
                lights_next[2*gi +: 2] = LAMP_RED;
                if (phase_next == PH_RESET) begin
                    lights_next[2*gi +: 2] = LAMP_OFF;
                end else if (cur_dir_next == DIR_W'(gi)) begin
                    if (phase_next == PH_GREEN) begin
                        lights_next[2*gi +: 2] = LAMP_GREEN;
                    end else if (phase_next == PH_YELLOW) begin
                        lights_next[2*gi +: 2] = LAMP_YELLOW;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg       <= PH_RESET;
            cur_dir_reg     <= DIR_W'(NUM_DIR - 1);
            lights_reg      <= '0;
            phase_start_reg <= 1'b0;
            tick_cnt_reg    <= '0;
            sec_cnt_reg     <= '0;
        end else begin
            phase_reg       <= phase_next;
            cur_dir_reg     <= cur_dir_next;
            lights_reg      <= lights_next;
            phase_start_reg <= enter_next;
            if (enter_next) begin
                tick_cnt_reg <= '0;
                sec_cnt_reg  <= sec_load_next;
            end else if (!hold) begin
                tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TCW'(1);
                if (tick) begin
                    sec_cnt_reg <= sec_cnt_reg - DATA_WIDTH'(1);
                end
            end
        end
    end

    assign phase       = phase_reg;
    assign cur_dir     = cur_dir_reg;
    assign lights      = lights_reg;
    assign phase_start = phase_start_reg;
endmodule

// File: tb/tb_tlc_multi.sv
// Bench for tlc_multi: directed scenarios followed by random traffic, every cycle
// compared against a clock-counting phase model.
module tb_tlc_multi;
    localparam int NUM_DIR = 4;
    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int TD      = 4;
    localparam int DIR_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 hold = 1'b0;
    logic [1:0]           phase;
    logic [DIR_W-1:0]     cur_dir;
    logic [2*NUM_DIR-1:0] lights;
    logic                 phase_start;

    tlc_multi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    always #5 clk = ~clk;

    tlc_multi #(
        .NUM_DIR(NUM_DIR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TICK_DIV(TD), .DIR_W(DIR_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .hold(hold), .phase(phase),
        .cur_dir(cur_dir), .lights(lights), .phase_start(phase_start)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Model: phase, owner and clocks remaining in the phase.
    int m_ph, m_cur, m_rem, m_ty, m_tar;
    int m_tg [NUM_DIR];
    bit m_rdy, m_err, m_ps;

    function automatic int m_dur(input int p, input int dir);
        if (p == 1)      return (m_tar == 0) ? 1 : m_tar * TD;
        else if (p == 3) return m_tg[dir] * TD;
        else             return ((m_ty == 0) ? 1 : m_ty) * TD;
    endfunction

    function automatic logic [7:0] m_lights();
        logic [7:0] l = 8'h00;
        if (m_ph != 0) begin
            for (int i = 0; i < NUM_DIR; i++) begin
                if (i == m_cur && m_ph == 3)      l[2*i +: 2] = 2'b11;
                else if (i == m_cur && m_ph == 2) l[2*i +: 2] = 2'b10;
                else                              l[2*i +: 2] = 2'b01;
            end
        end
        return l;
    endfunction

    task automatic m_enter(input int p);
        m_ph  = p;
        m_rem = m_dur(p, m_cur);
        m_ps  = 1'b1;
    endtask

    task automatic model_step(input bit r, input bit v, input int a, input int d, input bit h);
        int nxt;
        if (r) begin
            m_ph = 0; m_cur = NUM_DIR - 1; m_rem = 0; m_ty = 0; m_tar = 0;
            for (int i = 0; i < NUM_DIR; i++) m_tg[i] = 0;
            m_rdy = 0; m_err = 0; m_ps = 0;
        end else begin
            m_ps = 0;
            if (m_ph == 0) begin
                m_enter(1);
            end else if (!h) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_ph == 1) begin
                        nxt = -1;
                        for (int k = 1; k <= NUM_DIR; k++) begin
                            if (nxt < 0 && m_tg[(m_cur + k) % NUM_DIR] != 0) nxt = (m_cur + k) % NUM_DIR;
                        end
                        if (nxt >= 0) begin
                            m_cur = nxt;
                            m_enter(3);
                        end else begin
                            m_enter(1);
                        end
                    end else if (m_ph == 3) begin
                        m_enter(2);
                    end else begin
                        m_enter(1);
                    end
                end
            end
            m_rdy = v && (a < NUM_DIR + 2);
            m_err = v && !(a < NUM_DIR + 2);
            if (v && a < NUM_DIR)       m_tg[a] = d;
            else if (v && a == NUM_DIR) m_ty = d;
            else if (v && a == NUM_DIR + 1) m_tar = d;
        end
    endtask

    int glen[$];
    int gdir[$];
    int cur_len = 0;
    int last_ph = 0;

    task automatic step(input bit r, input bit v, input int a, input int d, input bit h);
        int nonred;
        rst = r; bus.valid = v; bus.addr = a[AW-1:0]; bus.data = d[DW-1:0]; hold = h;
        @(posedge clk);
        model_step(r, v, a, d, h);
        #1;
        check("phase", phase, m_ph);
        check("cur_dir", cur_dir, m_cur);
        check("lights", lights, m_lights());
        check("phase_start", phase_start, m_ps);
        check("ready", bus.ready, m_rdy);
        check("err", bus.err, m_err);
        if (phase != 2'b00) begin
            nonred = 0;
            for (int i = 0; i < NUM_DIR; i++) if (lights[2*i +: 2] != 2'b01) nonred++;
            check("safety", (nonred <= 1) ? 1 : 0, 1);
        end
        if (r) begin
            last_ph = 0; cur_len = 0;
        end else if (phase_start) begin
            if (last_ph == 3) glen.push_back(cur_len);
            if (phase == 2'b11) gdir.push_back(int'(cur_dir));
            last_ph = int'(phase);
            cur_len = 1;
        end else begin
            cur_len++;
        end
        $display("t=%0t rst=%0b v=%0b a=%0d d=%0d h=%0b | ph=%0d dir=%0d lights=%02h ps=%0b rdy=%0b err=%0b",
                 $time, r, v, a, d, h, phase, cur_dir, lights, phase_start, bus.ready, bus.err);
    endtask

    task automatic run_until(input int ph, input int dir, input int budget);
        int n = 0;
        while (!(phase_start && phase == ph[1:0] && cur_dir == dir[DIR_W-1:0]) && n < budget) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        check("wait_phase", (n < budget) ? 1 : 0, 1);
    endtask

    int exp_glen [4] = '{8, 12, 18, 20};
    int exp_gdir [4] = '{0, 2, 0, 2};
    int wr_data  [6] = '{2, 0, 3, 0, 1, 1};

    initial begin
        bus.valid = 1'b0; bus.addr = '0; bus.data = '0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // Empty registers: all-red re-entered every clock.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        check("s1_lights", lights, 8'h55);
        check("s1_ps", phase_start, 1);

        // Program timing, then an invalid address.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, i, wr_data[i], 0);
            check("s2_ready", bus.ready, 1);
        end
        step(0, 1, 9, 7, 0);
        check("s2_err", bus.err, 1);

        // Rotation with a mid-green rewrite of the active approach and of yellow.
        run_until(3, 2, 200);
        step(0, 1, 2, 5, 0);
        step(0, 1, 4, 0, 0);
        run_until(3, 0, 200);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
        run_until(3, 2, 300);
        run_until(2, 2, 300);

        check("n_greens", glen.size(), 4);
        for (int i = 0; i < 4 && i < glen.size(); i++) check("green_len", glen[i], exp_glen[i]);
        for (int i = 0; i < 4 && i < gdir.size(); i++) check("green_dir", gdir[i], exp_gdir[i]);

        // Abort during yellow.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("s6_phase", phase, 0);
        check("s6_lights", lights, 0);
        check("s6_tgreen2", dut.tgreen_reg[2], 0);
        check("s6_tallred", dut.tallred_reg, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        check("s6_loop_lights", lights, 8'h55);
        check("s6_loop_ps", phase_start, 1);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tlc_multi.md
Name: tlc_multi

Overview:
- Parametrised multi-approach traffic light controller. Successor to the single-approach red/yellow/green controller.
- Serves NUM_DIR approaches in round-robin: green, then yellow, then an all-red clearance, then the next approach's green.
- Per-approach green times, a shared yellow time and a shared all-red time are programmed in seconds over the same addr/data/valid/ready write port.
- Time base is an internal prescaler tick; phases are counted in whole seconds.
- Sits between the intersection host (register master) and the lamp drivers.

Parameters:
- NUM_DIR, 4, number of approaches (2..8).
- DATA_WIDTH, 8, width of the timing registers and data bus, in seconds.
- ADDR_WIDTH, 4, address bus width; must satisfy 2^ADDR_WIDTH >= NUM_DIR+2.
- TICK_DIV, 1000, clk cycles per one-second tick (>=1).
- DIR_W, $clog2(NUM_DIR), width of the direction index.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, reset, synchronous, active-high.
- addr, in, ADDR_WIDTH, register address for a write.
- data, in, DATA_WIDTH, write data in seconds.
- valid, in, 1, master write request; each cycle high is one write.
- hold, in, 1, freezes the prescaler and phase timer while high.
- ready, out, 1, registered acknowledge of an accepted write.
- err, out, 1, registered flag for a write to an invalid address.
- phase, out, 2, current phase: RESET=00, ALLRED=01, YELLOW=10, GREEN=11.
- cur_dir, out, DIR_W, approach owning the current or most recent green.
- lights, out, 2*NUM_DIR, per-approach lamp code at bits [2i+1:2i]: OFF=00, RED=01, YELLOW=10, GREEN=11.
- phase_start, out, 1, one-cycle pulse on the first cycle of every new phase.

Behaviour:
- Register map:
  - addr 0..NUM_DIR-1: TGreen[i].
  - addr NUM_DIR: TYellow.
  - addr NUM_DIR+1: TAllRed.
  - Any other address: invalid.
- All registers reset to 0.
- Write handshake, when not in reset:
  - valid=1 with a valid addr: register is written at that edge; next cycle ready=1, err=0.
  - valid=1 with an invalid addr: nothing is written; next cycle ready=0, err=1.
  - valid=0: next cycle ready=0, err=0.
- A write never alters a running timer. New values apply at the next load of that phase.
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1; tick is asserted when tick_cnt==TICK_DIV-1 and hold=0.
  - tick_cnt clears on every phase entry.
  - hold=1 freezes tick_cnt and sec_cnt; the phase is unchanged.
- Phase timer:
  - On phase entry, sec_cnt is loaded with the phase duration; each tick decrements it.
  - The phase exits on the tick where sec_cnt==1, so a phase lasts duration*TICK_DIV clocks when hold stays low.
- Reset:
  - While rst=1: phase=RESET, lights all OFF, cur_dir=NUM_DIR-1, ready=err=phase_start=0, registers=0, counters=0.
  - rst wins over valid in the same cycle.
  - rst mid-phase aborts immediately; no yellow or all-red is run on abort.
- After reset:
  - First cycle with rst=0: phase=RESET, lights all OFF.
  - Next edge: ALLRED, with phase_start=1.
- ALLRED:
  - All lights RED. Duration is TAllRed.
  - If TAllRed==0, the phase lasts exactly 1 clock.
  - On exit, search cur_dir+1, cur_dir+2, ... cyclically, ending at cur_dir itself, for the first approach with TGreen!=0.
  - If one is found: go to GREEN and set cur_dir to it.
  - If none is found: re-enter ALLRED (phase_start pulses again).
- GREEN:
  - lights[cur_dir]=GREEN; all others RED. Duration is TGreen[cur_dir], latched at entry.
  - Exits to YELLOW.
- YELLOW:
  - lights[cur_dir]=YELLOW; all others RED.
  - Duration is max(TYellow,1) seconds; yellow is never skipped.
  - Exits to ALLRED.
- Safety invariant: at most one approach is non-RED in any non-RESET phase. The bench asserts this continuously.
- All outputs are registered. lights, phase and cur_dir change on the same edge as phase_start.

Test Plan:
1. Reset and empty registers (TICK_DIV=4, NUM_DIR=4): release rst with no writes -> RESET for 1 cycle, then ALLRED re-entered every clock, phase_start high each cycle, lights=8'h55.
2. Write handshake: write addr 0..5 = 2,0,3,0,1,1, then addr 9 -> ready=1 one cycle after each of the first six writes; for addr 9, err=1 and no register changes.
3. Full rotation (values from scenario 2):
   - Green on dir0 for 8 clocks, yellow 4, all-red 4.
   - Green on dir2 for 12 clocks; dirs 1 and 3 are skipped.
   - Then back to dir0.
   - Check cur_dir sequence 0,2,0.
4. Hold: assert hold for 10 cycles mid-GREEN -> GREEN duration stretches by exactly 10 clocks; lights stable throughout.
5. Write to the active approach mid-phase: set TGreen[2]=5 during dir2 green -> the current green stays 12 clocks; the next dir2 green lasts 20 clocks. Also set TYellow=0 -> yellow lasts 4 clocks.
6. Mid-phase reset: assert rst during YELLOW -> next edge phase=RESET, lights=0, registers read back 0; after release, ALLRED loops as in scenario 1.
